addsub_sequencer: RTL and testbench

ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

---
 rtl/addsub_sequencer.sv | 138 +++++++++++++
 tb/tb_addsub_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// Sequences one add/subtract command at a time through an external combinational
// Adder_Subtractor. Optional signed-overflow output is enabled by ADDSUB_SEQ_OVF_EN.
module addsub_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_a,
    input  logic [5:0] in_b,
    input  logic       in_sub,
    input  logic       in_acc,
    output logic [5:0] addsub_a,
    output logic [5:0] addsub_b,
    output logic       addsub_s,
    input  logic [5:0] addsub_answer,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_result
`ifdef ADDSUB_SEQ_OVF_EN
    ,
    output logic       out_ovf
`endif
);

    // state  | meaning
    // IDLE   | waiting for a command; only state that accepts one
    // SETTLE | operands held on the adder while the answer settles
    // RESULT | result captured and offered until the consumer takes it
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

    // The counter is loaded at acceptance; the edge that sees zero is the capture edge.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic [5:0] acc;
    logic       accept;
    logic       capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESULT;
                end
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= 4'd0;
        end else if (accept) begin
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addsub_a   <= 6'd0;
            addsub_b   <= 6'd0;
            addsub_s   <= 1'b0;
            out_result <= 6'd0;
            acc        <= 6'd0;
        end else begin
            if (accept) begin
                addsub_a <= in_acc ? acc : in_a;
                addsub_b <= in_b;
                addsub_s <= in_sub;
            end
            if (capture) begin
                out_result <= addsub_answer;
                acc        <= addsub_answer;
            end
        end
    end

`ifdef ADDSUB_SEQ_OVF_EN
    logic ovf_now;

    // Subtraction overflows when the operand signs differ; addition when they match.
    always_comb begin
        if (addsub_s) begin
            ovf_now = (addsub_a[5] != addsub_b[5]) && (addsub_answer[5] != addsub_a[5]);
        end else begin
            ovf_now = (addsub_a[5] == addsub_b[5]) && (addsub_answer[5] != addsub_a[5]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_ovf <= 1'b0;
        end else if (capture) begin
            out_ovf <= ovf_now;
        end
    end
`endif

endmodule

// File: tb/tb_addsub_sequencer.sv
// Bench for addsub_sequencer: two instances (settle 1 and settle 4), each wired to a
// behavioural Adder_Subtractor; results are checked through a queue scoreboard.
module tb_addsub_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance with SETTLE_CYCLES = 1 ----------------
    logic       rst, iv, ir, sub, acc, as, ov, ordy;
    logic [5:0] a, b, aa, ab, ans, res;
    assign ans = as ? (aa - ab) : (aa + ab);
`ifdef ADDSUB_SEQ_OVF_EN
    logic       ovf;
`endif

    addsub_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir),
        .in_a(a), .in_b(b), .in_sub(sub), .in_acc(acc),
        .addsub_a(aa), .addsub_b(ab), .addsub_s(as), .addsub_answer(ans),
        .out_valid(ov), .out_ready(ordy), .out_result(res)
`ifdef ADDSUB_SEQ_OVF_EN
        , .out_ovf(ovf)
`endif
    );

    // ---------------- instance with SETTLE_CYCLES = 4 ----------------
    logic       rst4, iv4, ir4, sub4, acc4, as4, ov4, ordy4;
    logic [5:0] a4, b4, aa4, ab4, ans4, res4;
    assign ans4 = as4 ? (aa4 - ab4) : (aa4 + ab4);
`ifdef ADDSUB_SEQ_OVF_EN
    logic       ovf4;
`endif

    addsub_sequencer #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .reset(rst4), .in_valid(iv4), .in_ready(ir4),
        .in_a(a4), .in_b(b4), .in_sub(sub4), .in_acc(acc4),
        .addsub_a(aa4), .addsub_b(ab4), .addsub_s(as4), .addsub_answer(ans4),
        .out_valid(ov4), .out_ready(ordy4), .out_result(res4)
`ifdef ADDSUB_SEQ_OVF_EN
        , .out_ovf(ovf4)
`endif
    );

    typedef struct packed {
        logic [5:0] res;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic       sub;
        logic       acc;
        logic [5:0] res;
        logic       ovf;
    } vec_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard: a result is consumed when out_valid and out_ready meet.
    always @(negedge clk) begin
        if (!rst && ov && ordy) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", int'(res), int'(e.res));
`ifdef ADDSUB_SEQ_OVF_EN
                chk("sb_ovf", int'(ovf), int'(e.ovf));
`endif
            end
        end
    end

    task automatic send(input logic [5:0] ia, input logic [5:0] ib, input logic isub,
                        input logic iacc, input logic [5:0] eres, input logic eovf,
                        input bit keep);
        exp_t e;
        a = ia; b = ib; sub = isub; acc = iacc; iv = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (ir) break;
            @(posedge clk); #1;
        end
        if (!ir) begin
            chk("accept_timeout", 0, 1);
            iv = 1'b0;
        end else begin
            e.res = eres;
            e.ovf = eovf;
            sb.push_back(e);
            @(posedge clk); #1;
            if (!keep) iv = 1'b0;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 40; t++) begin
            if (sb.size() == 0 && ir) break;
            @(posedge clk); #1;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        rst = 1'b1; iv = 1'b0; a = 6'd0; b = 6'd0; sub = 1'b0; acc = 1'b0; ordy = 1'b1;
        rst4 = 1'b1; iv4 = 1'b0; a4 = 6'd0; b4 = 6'd0; sub4 = 1'b0; acc4 = 1'b0; ordy4 = 1'b1;

        vecs[0] = '{6'd15, 6'd33, 1'b0, 1'b0, 6'd48, 1'b0};
        vecs[1] = '{6'd0,  6'd20, 1'b0, 1'b1, 6'd4,  1'b0};
        vecs[2] = '{6'd15, 6'd33, 1'b1, 1'b0, 6'd46, 1'b1};
        vecs[3] = '{6'd0,  6'd1,  1'b1, 1'b1, 6'd45, 1'b0};
        vecs[4] = '{6'd31, 6'd1,  1'b0, 1'b0, 6'd32, 1'b1};
        vecs[5] = '{6'd0,  6'd32, 1'b0, 1'b1, 6'd0,  1'b1};
        vecs[6] = '{6'd63, 6'd63, 1'b0, 1'b0, 6'd62, 1'b0};
        vecs[7] = '{6'd0,  6'd0,  1'b1, 1'b1, 6'd62, 1'b0};
        vecs[8] = '{6'd32, 6'd1,  1'b1, 1'b0, 6'd31, 1'b1};
        vecs[9] = '{6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  1'b0};

        // Reset with a concurrent command: reset wins, nothing is latched.
        iv = 1'b1; a = 6'd7; b = 6'd9; sub = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_prio_a", int'(aa), 0);
        chk("rst_prio_s", int'(as), 0);
        iv = 1'b0; rst = 1'b0; rst4 = 1'b0;
        chk("rst_in_ready", int'(ir), 1);
        chk("rst_out_valid", int'(ov), 0);
        chk("rst_out_result", int'(res), 0);
        chk("rst_addsub_b", int'(ab), 0);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].acc, vecs[i].res, vecs[i].ovf, 1'b0);
        end
        drain();

        // Backpressure, latency and operand hold.
        ordy = 1'b0;
        send(6'd15, 6'd33, 1'b0, 1'b0, 6'd48, 1'b0, 1'b0);
        chk("bp_settle_valid", int'(ov), 0);
        chk("bp_settle_ready", int'(ir), 0);
        chk("bp_latched_a", int'(aa), 15);
        chk("bp_latched_b", int'(ab), 33);
        @(posedge clk); #1;
        chk("bp_latency_valid", int'(ov), 1);
        iv = 1'b1; a = 6'd7; b = 6'd7; sub = 1'b1; acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", int'(ov), 1);
            chk("bp_hold_result", int'(res), 48);
            chk("bp_hold_ready", int'(ir), 0);
            chk("bp_hold_a", int'(aa), 15);
            chk("bp_hold_s", int'(as), 0);
            @(posedge clk); #1;
        end
        iv = 1'b0; ordy = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", int'(ir), 1);
        chk("bp_release_valid", int'(ov), 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("bp_no_extra", sb.size(), 0);
        chk("bp_a_after", int'(aa), 15);

        // Reset clears the accumulator; then signed overflow on 31+1.
        do_reset();
        send(6'd0, 6'd5, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0);
        send(6'd31, 6'd1, 1'b0, 1'b0, 6'd32, 1'b1, 1'b0);
        drain();

        // Back-to-back with in_valid and out_ready held high.
        do_reset();
        pop_cyc.delete();
        send(6'd5, 6'd9,  1'b0, 1'b0, 6'd14, 1'b0, 1'b1);
        send(6'd0, 6'd3,  1'b1, 1'b1, 6'd11, 1'b0, 1'b1);
        send(6'd0, 6'd60, 1'b0, 1'b1, 6'd7,  1'b0, 1'b0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("b2b_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            chk("b2b_gap1", pop_cyc[1] - pop_cyc[0], 3);
            chk("b2b_gap2", pop_cyc[2] - pop_cyc[1], 3);
        end
        chk("b2b_sb_empty", sb.size(), 0);

        // SETTLE_CYCLES=4: full command, then abort mid-settle with reset.
        iv4 = 1'b1; a4 = 6'd10; b4 = 6'd5; sub4 = 1'b0; acc4 = 1'b0;
        @(posedge clk); #1;
        iv4 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("s4_latency_early", int'(ov4), 0);
        @(posedge clk); #1;
        chk("s4_latency_valid", int'(ov4), 1);
        chk("s4_result", int'(res4), 15);
        @(posedge clk); #1;
        chk("s4_idle", int'(ir4), 1);

        iv4 = 1'b1; a4 = 6'd0; b4 = 6'd5; acc4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        chk("s4_abort_settle", int'(ir4), 0);
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        chk("s4_abort_ready", int'(ir4), 1);
        chk("s4_abort_valid", int'(ov4), 0);
        chk("s4_abort_result", int'(res4), 0);
        chk("s4_abort_a", int'(aa4), 0);
        chk("s4_abort_b", int'(ab4), 0);
        chk("s4_abort_s", int'(as4), 0);
`ifdef ADDSUB_SEQ_OVF_EN
        chk("s4_abort_ovf", int'(ovf4), 0);
`endif
        begin
            int pulses = 0;
            for (int i = 0; i < 8; i++) begin
                if (ov4) pulses++;
                @(posedge clk); #1;
            end
            chk("s4_abort_no_pulse", pulses, 0);
        end

        iv4 = 1'b1; a4 = 6'd9; b4 = 6'd0; acc4 = 1'b1; sub4 = 1'b0;
        @(posedge clk); #1;
        iv4 = 1'b0;
        chk("s4_acc_operand", int'(aa4), 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("s4_acc_valid", int'(ov4), 1);
        chk("s4_acc_cleared", int'(res4), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
